// File: rtl/pipe_ctl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states, MIPS opcodes, flush counter width.
package pipe_ctl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } ctl_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Enough for FLUSH_CYC-1 with FLUSH_CYC up to 8.
    localparam int FLUSH_CNT_W = 3;

    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/hazard_ctl_lu_detect.sv
// Load-use hazard compare between the IF/ID instruction sources and a load in ID/EX.
// Purely combinational.
module lu_detect
    import pipe_ctl_pkg::*;
(
    input  logic [15:0] id_inst_hi,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        lu_haz
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;

    assign opcode  = id_inst_hi[15:10];
    assign rs      = id_inst_hi[9:5];
    assign rt      = id_inst_hi[4:0];
    assign uses_rt = op_uses_rt(opcode);

    assign lu_haz = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((ex_rd == rs) || (uses_rt && (ex_rd == rt)));

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline sequencing FSM: load-use stall, branch/jump squash, data-memory freeze.
// Define HAZARD_STATS_EN to add saturating stall_cnt / flush_cnt statistics ports.
module hazard_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_inst,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]       ctl_state
);

    localparam logic [FLUSH_CNT_W-1:0] RELOAD = FLUSH_CNT_W'(FLUSH_CYC - 1);

    ctl_state_e             state_q, state_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   lu_haz;
    logic                   eval_run;
    logic                   stall_evt;
    logic                   unused_inst_lo;

    assign unused_inst_lo = ^id_inst[15:0];

    lu_detect u_lu_detect (
        .id_inst_hi  (id_inst[31:16]),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .lu_haz      (lu_haz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        eval_run     = 1'b0;
        stall_evt    = 1'b0;

        case (state_q)
            ST_RUN: eval_run = 1'b1;
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                end else begin
                    eval_run = 1'b1;
                end
            end
            ST_FLUSH: begin
                // A freeze during the squash window parks the countdown.
                if (mem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    ex_mem_hold = 1'b1;
                end else if (ex_br_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_d        = RELOAD;
                    state_d      = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
                end else begin
                    if_id_flush = 1'b1;
                    if (cnt_q <= FLUSH_CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - FLUSH_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase

        // MEM_WAIT falls through here on its exit cycle so held requests are serviced.
        if (eval_run) begin
            state_d = ST_RUN;
            if (mem_busy) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                ex_mem_hold = 1'b1;
                state_d     = ST_MEM_WAIT;
            end else if (ex_br_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (FLUSH_CYC > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = RELOAD;
                end
            end else if (lu_haz) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                stall_evt    = 1'b1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
            end
        end
    end

    assign ctl_state = state_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (if_id_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic [CNT_W:0] unused_stats;
    assign unused_stats = {CNT_W'(0), stall_evt};
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed scenarios plus randomized run against a behavioural model.
module tb_hazard_ctl;

    localparam int FLUSH_CYC = 3;
    localparam int CNT_W     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_inst;
    logic        id_jump;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_br_taken;
    logic        mem_busy;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_hold;
    logic [1:0]  ctl_state;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, ctl_state}
    logic [6:0] obs;
    assign obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, ctl_state};

    localparam logic [31:0] ADD_9_8_10 = 32'h010A4820;
    localparam logic [31:0] LW_8_9     = 32'h8D280000;
    localparam logic [31:0] SW_8_9     = 32'hAD280000;
    localparam logic [31:0] ADD_8_0_0  = 32'h00004020;

    always #5 clk = ~clk;

    hazard_ctl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_inst      (id_inst),
        .id_jump      (id_jump),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_br_taken  (ex_br_taken),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .ex_mem_hold  (ex_mem_hold),
`ifdef HAZARD_STATS_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .ctl_state    (ctl_state)
    );

    // Apply one cycle of inputs mid-cycle, then settle before sampling.
    task automatic drive(input logic [31:0] inst, input logic jmp, input logic mr,
                         input logic [4:0] rd, input logic br, input logic busy);
        @(negedge clk);
        id_inst     = inst;
        id_jump     = jmp;
        ex_mem_read = mr;
        ex_rd       = rd;
        ex_br_taken = br;
        mem_busy    = busy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        id_inst = '0; id_jump = 0; ex_mem_read = 0; ex_rd = '0; ex_br_taken = 0; mem_busy = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_inst = '0; id_jump = 0; ex_mem_read = 0; ex_rd = '0; ex_br_taken = 0; mem_busy = 0;
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 7'b1100000);
        end
`ifdef HAZARD_STATS_EN
        n_checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        drive(ADD_9_8_10, 0, 1, 5'd8, 0, 0);
        n_checks++;
        if (obs !== 7'b0001000) begin
            n_fail++;
            $display("FAIL lu_stall: got %b expected %b", obs, 7'b0001000);
        end
        drive(ADD_9_8_10, 0, 0, 5'd0, 0, 0);
        n_checks++;
        if (obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL lu_after: got %b expected %b", obs, 7'b1100000);
        end
        drive(ADD_8_0_0, 0, 1, 5'd0, 0, 0);
        n_checks++;
        if (obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL lu_rd_zero: got %b expected %b", obs, 7'b1100000);
        end
        drive(LW_8_9, 0, 1, 5'd8, 0, 0);
        n_checks++;
        if (obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL lu_lw_rt_unused: got %b expected %b", obs, 7'b1100000);
        end
        drive(SW_8_9, 0, 1, 5'd8, 0, 0);
        n_checks++;
        if (obs !== 7'b0001000) begin
            n_fail++;
            $display("FAIL lu_sw_rt_used: got %b expected %b", obs, 7'b0001000);
        end
        drive(32'h0, 0, 0, 5'd0, 0, 0);
    endtask

    task automatic test_branch_flush();
        logic [6:0] exp_seq [4];
        exp_seq[0] = 7'b1111000;
        exp_seq[1] = 7'b1110001;
        exp_seq[2] = 7'b1110001;
        exp_seq[3] = 7'b1100000;
        for (int i = 0; i < 4; i++) begin
            drive(32'h0, 0, 0, 5'd0, (i == 0), 0);
            n_checks++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL branch_flush cyc%0d: got %b expected %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_mem_freeze();
        logic [6:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            drive(ADD_9_8_10, 0, (i < 5), 5'd8, 0, (i < 4));
            exp_v = (i == 0) ? 7'b0000100 :
                    (i < 4)  ? 7'b0000110 :
                    (i == 4) ? 7'b0001010 : 7'b1100000;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mem_freeze cyc%0d: got %b expected %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_branch_vs_lu_and_reset();
        drive(ADD_9_8_10, 0, 1, 5'd8, 1, 0);
        n_checks++;
        if (obs !== 7'b1111000) begin
            n_fail++;
            $display("FAIL br_beats_lu: got %b expected %b", obs, 7'b1111000);
        end
        drive(32'h0, 0, 0, 5'd0, 0, 0);
        n_checks++;
        if (obs !== 7'b1110001) begin
            n_fail++;
            $display("FAIL br_in_flush: got %b expected %b", obs, 7'b1110001);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL async_reset_flush: got %b expected %b", obs, 7'b1100000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0]  ops [7];
        logic [31:0] inst;
        logic        jmp, mr, br, busy, lu, uses_rt;
        logic [4:0]  rd, rs, rt;
        logic [6:0]  exp_v;
        int          flush_rem;
        bit          prev_busy;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        ops[4] = 6'h05; ops[5] = 6'h02; ops[6] = 6'h08;
        do_reset();
        flush_rem = 0;
        prev_busy = 0;
        for (int i = 0; i < 400; i++) begin
            rs   = 5'($urandom_range(0, 3));
            rt   = 5'($urandom_range(0, 3));
            inst = {ops[$urandom_range(0, 6)], rs, rt, 16'($urandom)};
            rd   = 5'($urandom_range(0, 3));
            mr   = 1'($urandom_range(0, 1));
            jmp  = ($urandom_range(0, 7) == 0);
            br   = ($urandom_range(0, 9) == 0);
            busy = ($urandom_range(0, 5) == 0);
            drive(inst, jmp, mr, rd, br, busy);

            uses_rt = (inst[31:26] == 6'h00) || (inst[31:26] == 6'h2B) ||
                      (inst[31:26] == 6'h04) || (inst[31:26] == 6'h05);
            lu = mr && (rd != 0) && ((rd == rs) || (uses_rt && (rd == rt)));

            exp_v[1:0] = (flush_rem > 0) ? 2'd1 : (prev_busy ? 2'd2 : 2'd0);
            exp_v[6:2] = 5'b11000;
            if (busy) begin
                exp_v[6:2] = 5'b00001;
            end else if (br) begin
                exp_v[6:2] = 5'b11110;
                flush_rem  = FLUSH_CYC - 1;
            end else if (flush_rem > 0) begin
                exp_v[6:2] = 5'b11100;
                flush_rem--;
            end else if (lu) begin
                exp_v[6:2] = 5'b00010;
            end else if (jmp) begin
                exp_v[6:2] = 5'b11100;
            end
            prev_busy = busy;

            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %b expected %b", i, obs, exp_v);
            end
        end
        drive(32'h0, 0, 0, 5'd0, 0, 0);
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(ADD_9_8_10, 0, 1, 5'd8, 0, 0);
            drive(32'h0, 0, 0, 5'd0, 0, 0);
        end
        drive(32'h0, 1, 0, 5'd0, 0, 0);
        drive(32'h0, 0, 0, 5'd0, 0, 0);
        n_checks++;
        if (stall_cnt !== 2'd3 || flush_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL stats_count: got stall=%0d flush=%0d expected 3/1", stall_cnt, flush_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            drive(ADD_9_8_10, 0, 1, 5'd8, 0, 0);
            drive(32'h0, 0, 0, 5'd0, 0, 0);
        end
        n_checks++;
        if (stall_cnt !== 2'd3 || flush_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL stats_saturate: got stall=%0d flush=%0d expected 3/1", stall_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_flush();
        test_mem_freeze();
        test_branch_vs_lu_and_reset();
        test_random();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
